cordic_atan_seq: RTL and testbench
==================================

Name: cordic_atan_seq

Overview:
- Iterative vectoring-mode CORDIC controller computing atan2(y,x) and the vector magnitude.
- Time-multiplexes one shift/add micro-rotation datapath over ITER cycles, one cycle per shift index, instead of an unrolled chain of stages.
- Sequences quadrant pre-rotation, shift index and angle-table lookup, with valid/ready handshakes on both sides.
- Sits between the sample front end and the phase-tracking logic.

Parameters:
- ITER, 12, number of micro-rotations (legal 1..12); shift index runs 0..ITER-1.
- DW, 32, signed input width of x and y.

Ports:
- rx_clk  input  1  clock; all logic on the rising edge.
- rx_rst  input  1  synchronous reset, active-low.
- rx_valid  input  1  input vector valid.
- rx_ready  output  1  block can accept a vector.
- rx_x  input  DW  signed x.
- rx_y  input  DW  signed y.
- rx_flush  input  1  synchronous abort of any operation in flight.
- tx_valid  output  1  result valid.
- tx_ready  input  1  downstream accepts result.
- tx_z  output  12  angle; full circle = 4096, unsigned, wraps mod 4096.
- tx_mag  output  DW+2  unsigned magnitude.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset (rx_rst=0 at a clock edge): state IDLE; rx_ready=1; tx_valid=0; busy=0; tx_z=0; tx_mag=0; all internal registers 0. Reset overrides any state, including mid-iteration.
- FSM states: IDLE, RUN, DONE (plus GAIN when the optional feature is compiled in).
- IDLE
  - rx_ready=1.
  - On rx_valid & rx_ready: capture the vector and go to RUN with iteration counter i=0.
  - Capture is pre-rotated, extended to DW+2 bits:
    - x<0: x0=-x, y0=-y, z0=2048.
    - otherwise: x0=x, y0=y, z0=0.
- RUN (one micro-rotation per cycle, index i)
  - If y[MSB] XOR x[MSB]: x=x-(y>>>i), y=y+(x>>>i), z=z-A[i].
  - Else: x=x+(y>>>i), y=y-(x>>>i), z=z+A[i].
  - Shifts are arithmetic. Both updates use the pre-cycle x and y.
  - z arithmetic is 12-bit modulo.
  - Angle table A[0..11] = 512, 302, 160, 81, 41, 20, 10, 5, 3, 1, 1, 0.
  - After i=ITER-1, go to DONE.
- DONE
  - tx_valid=1; tx_z=z; tx_mag=x, always non-negative after pre-rotation.
  - Outputs are held stable while tx_ready=0.
  - On tx_ready: tx_valid drops next cycle and state returns to IDLE.
- Latency: accept edge to tx_valid high is ITER+1 cycles. Throughput: one vector per ITER+2 cycles, no overlap.
- rx_ready=0 whenever state≠IDLE; rx_valid is ignored then.
- rx_flush=1 in any state: next state IDLE, tx_valid=0, result discarded. Flush wins over a simultaneous accept or tx handshake.
- Input x=0,y=0: result z=0, mag=0.
- x = most-negative DW value: the negation is exact in DW+2 bits; no overflow.
- Internal x/y width DW+2 covers CORDIC gain × √2 headroom.

Optional Feature:
- Macro: CORDIC_GAIN_COMP_EN.
- When defined:
  - An extra GAIN state of 1 cycle sits between RUN and DONE.
  - It computes tx_mag = (x>>1)+(x>>3)-(x>>6)-(x>>9), i.e. ≈0.6074·x, removing the CORDIC gain.
  - Latency becomes ITER+2.
- When undefined:
  - There is no GAIN state.
  - tx_mag is the raw gain-scaled x, ≈1.6468·|v|.

Test Plan:
- Reset low 3 cycles, then high → rx_ready=1, tx_valid=0, busy=0, tx_z=0, tx_mag=0.
- Axis and diagonal cases, tx_ready=1, ITER=12; all tx_z within ±3:

  | rx_x | rx_y | tx_z |
  |---|---|---|
  | 1000 | 1000 | 512 |
  | 0 | 1000 | 1024 |
  | -1000 | 0 | 2048 |
  | 1000 | -1000 | 3584 |

  tx_valid rises exactly 13 cycles after accept.
- Magnitude: (1000,0) → tx_mag ≈1647 ±3 without macro; ≈1000 ±3 with CORDIC_GAIN_COMP_EN, with latency 14.
- Backpressure: hold tx_ready=0 for 5 cycles in DONE → tx_valid, tx_z and tx_mag constant; rx_ready=0 throughout; a second rx_valid is not accepted until after the handshake.
- Flush and reset mid-operation:
  - Pulse rx_flush at RUN iteration 4 → IDLE next cycle, tx_valid never asserts.
  - Pulse rx_flush with rx_valid in IDLE → no capture.
  - rx_rst=0 during RUN → all outputs at reset values next cycle.
- Corner values: (0,0) → tx_z=0, tx_mag=0. (-2^31, -2^31) → tx_z=2560 ±3, no wrap or overflow of tx_mag.

Source files
------------

// File: rtl/cordic_atan_seq.sv
// cordic_atan_seq: iterative vectoring-mode CORDIC giving atan2(y,x) and magnitude.
// Define CORDIC_GAIN_COMP_EN to add a 1-cycle GAIN state that removes the CORDIC gain.
module cordic_atan_seq #(
  parameter int ITER = 12,
  parameter int DW   = 32
) (
  input  logic                 rx_clk,
  input  logic                 rx_rst,
  input  logic                 rx_valid,
  output logic                 rx_ready,
  input  logic signed [DW-1:0] rx_x,
  input  logic signed [DW-1:0] rx_y,
  input  logic                 rx_flush,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  output logic [11:0]          tx_z,
  output logic [DW+1:0]        tx_mag,
  output logic                 busy
);

  localparam int XW = DW + 2;

`ifdef CORDIC_GAIN_COMP_EN
  typedef enum logic [1:0] {IDLE, RUN, DONE, GAIN} state_t;
`else
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
`endif

  state_t state, state_nx;

  logic signed [XW-1:0] x, y;
  logic signed [XW-1:0] xs, ys;
  logic signed [XW-1:0] ext_x, ext_y;
  logic [11:0]          z;
  logic [3:0]           i;
  logic                 zero;
  logic                 last;
  logic                 neg;
  logic                 flip;

  function automatic logic [11:0] atan_lut(input logic [3:0] k);
    case (k)
      4'd0:    atan_lut = 12'd512;
      4'd1:    atan_lut = 12'd302;
      4'd2:    atan_lut = 12'd160;
      4'd3:    atan_lut = 12'd81;
      4'd4:    atan_lut = 12'd41;
      4'd5:    atan_lut = 12'd20;
      4'd6:    atan_lut = 12'd10;
      4'd7:    atan_lut = 12'd5;
      4'd8:    atan_lut = 12'd3;
      4'd9:    atan_lut = 12'd1;
      4'd10:   atan_lut = 12'd1;
      default: atan_lut = 12'd0;
    endcase
  endfunction

  assign ext_x = XW'(rx_x);
  assign ext_y = XW'(rx_y);
  assign flip  = rx_x[DW-1];
  assign xs    = x >>> i;
  assign ys    = y >>> i;
  assign last  = (i == 4'(ITER - 1));
  assign neg   = y[XW-1] ^ x[XW-1];

  always_ff @(posedge rx_clk) begin
    if (!rx_rst) state <= IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (rx_valid) state_nx = RUN;
`ifdef CORDIC_GAIN_COMP_EN
      RUN:  if (last) state_nx = GAIN;
      GAIN: state_nx = DONE;
`else
      RUN:  if (last) state_nx = DONE;
`endif
      DONE: if (tx_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (rx_flush) state_nx = IDLE;
  end

  always_comb begin
    rx_ready = (state == IDLE);
    busy     = (state != IDLE);
    tx_valid = (state == DONE);
    tx_z     = tx_valid ? z : 12'd0;
    tx_mag   = tx_valid ? $unsigned(x) : '0;
  end

  // A zero vector has no angle; freezing z keeps the result at 0.
  always_ff @(posedge rx_clk) begin
    if (!rx_rst) begin
      x    <= '0;
      y    <= '0;
      z    <= '0;
      i    <= '0;
      zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (rx_valid && !rx_flush) begin
            x    <= flip ? -ext_x : ext_x;
            y    <= flip ? -ext_y : ext_y;
            z    <= flip ? 12'd2048 : 12'd0;
            i    <= '0;
            zero <= (rx_x == '0) && (rx_y == '0);
          end
        end
        RUN: begin
          x <= neg ? x - ys : x + ys;
          y <= neg ? y + xs : y - xs;
          if (!zero)
            z <= neg ? z - atan_lut(i) : z + atan_lut(i);
          i <= i + 4'd1;
        end
`ifdef CORDIC_GAIN_COMP_EN
        GAIN: x <= (x >>> 1) + (x >>> 3) - (x >>> 6) - (x >>> 9);
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_atan_seq.sv
// tb_cordic_atan_seq: directed vectors checked against a real-valued atan2/magnitude model.
// Build with CORDIC_GAIN_COMP_EN to check the gain-compensated variant.
module tb_cordic_atan_seq;

  localparam int  ITER = 12;
  localparam int  DW   = 32;
  localparam real PI   = 3.14159265358979;
`ifdef CORDIC_GAIN_COMP_EN
  localparam int     LAT     = ITER + 2;
  localparam real    GC      = 0.607421875;
  localparam longint MAG1000 = 1000;
`else
  localparam int     LAT     = ITER + 1;
  localparam real    GC      = 1.0;
  localparam longint MAG1000 = 1647;
`endif

  logic                 clk = 1'b0;
  logic                 rx_rst = 1'b0;
  logic                 rx_valid = 1'b0;
  logic                 rx_flush = 1'b0;
  logic                 tx_ready = 1'b1;
  logic signed [DW-1:0] rx_x = '0;
  logic signed [DW-1:0] rx_y = '0;
  logic                 rx_ready;
  logic                 tx_valid;
  logic                 busy;
  logic [11:0]          tx_z;
  logic [DW+1:0]        tx_mag;

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;

  typedef struct {
    longint x;
    longint y;
    int     acc;
    int     lz;
    longint lm;
    int     lt;
  } exp_t;

  exp_t q[$];

  cordic_atan_seq #(.ITER(ITER), .DW(DW)) dut (
    .rx_clk   (clk),
    .rx_rst   (rx_rst),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .rx_x     (rx_x),
    .rx_y     (rx_y),
    .rx_flush (rx_flush),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .tx_z     (tx_z),
    .tx_mag   (tx_mag),
    .busy     (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input bit ok,
                       input longint act, input longint req);
    vectors++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  function automatic real gain();
    real k = 1.0;
    for (int n = 0; n < ITER; n++)
      k = k * $sqrt(1.0 + 1.0 / real'(longint'(1) << (2 * n)));
    return k;
  endfunction

  function automatic int ang_diff(input int a, input int b);
    int d = (a - b) & 4095;
    if (d >= 2048) d = d - 4096;
    return (d < 0) ? -d : d;
  endfunction

  function automatic int model_z(input longint x, input longint y);
    real a;
    if (x == 0 && y == 0) return 0;
    a = $atan2(real'(y), real'(x));
    if (a < 0.0) a = a + 2.0 * PI;
    return int'($floor(a * 4096.0 / (2.0 * PI) + 0.5)) % 4096;
  endfunction

  function automatic real model_mag(input longint x, input longint y);
    return $sqrt(real'(x) * real'(x) + real'(y) * real'(y)) * gain() * GC;
  endfunction

  // Compare process: every cycle with tx_valid is checked against the model.
  exp_t          cur;
  int            ez;
  real           em;
  real           dm;
  logic          pv = 1'b0;
  logic          pr = 1'b1;
  logic [11:0]   pz = '0;
  logic [DW+1:0] pm = '0;

  always @(negedge clk) begin
    if (rx_rst && tx_valid) begin
      if (q.size() == 0) begin
        check("spurious_tx_valid", 1'b0, 1, 0);
      end else begin
        cur = q[0];
        ez  = model_z(cur.x, cur.y);
        em  = model_mag(cur.x, cur.y);
        dm  = real'(tx_mag) - em;
        check("z_model", ang_diff(int'(tx_z), ez) <= 4, tx_z, ez);
        check("mag_model", ((dm < 0.0) ? -dm : dm) <= 5.0 + em * 2.0e-6,
              longint'(tx_mag), longint'(em));
        if (cur.lz >= 0)
          check("z_literal", ang_diff(int'(tx_z), cur.lz) <= cur.lt,
                tx_z, cur.lz);
        if (cur.lm >= 0)
          check("mag_literal",
                (longint'(tx_mag) >= cur.lm - cur.lt) &&
                (longint'(tx_mag) <= cur.lm + cur.lt),
                longint'(tx_mag), cur.lm);
        check("rx_ready_in_done", !rx_ready, rx_ready, 0);
        if (!pv) begin
          check("latency", (cyc - cur.acc) == LAT, cyc - cur.acc, LAT);
        end else if (!pr) begin
          check("hold_z", tx_z == pz, tx_z, pz);
          check("hold_mag", tx_mag == pm, longint'(tx_mag), longint'(pm));
        end
        if (tx_ready) void'(q.pop_front());
      end
    end
    pv <= tx_valid && rx_rst;
    pr <= tx_ready;
    pz <= tx_z;
    pm <= tx_mag;
  end

  task automatic send(input longint x, input longint y, input int lz,
                      input longint lm, input int lt, output int acc);
    exp_t e;
    int   n = 0;
    rx_x     = x[DW-1:0];
    rx_y     = y[DW-1:0];
    rx_valid = 1'b1;
    while (!rx_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    acc = cyc;
    if (!rx_ready) begin
      check("accept_timeout", 1'b0, 0, 1);
    end else begin
      e = '{x: x, y: y, acc: cyc, lz: lz, lm: lm, lt: lt};
      q.push_back(e);
      @(posedge clk); #1;
    end
    rx_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || q.size() != 0) && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 300) check("idle_timeout", 1'b0, q.size(), 0);
  endtask

  task automatic expect_reset_state(input string tag);
    check({tag, "_rx_ready"}, rx_ready == 1'b1, rx_ready, 1);
    check({tag, "_tx_valid"}, tx_valid == 1'b0, tx_valid, 0);
    check({tag, "_busy"}, busy == 1'b0, busy, 0);
    check({tag, "_tx_z"}, tx_z == 12'd0, tx_z, 0);
    check({tag, "_tx_mag"}, tx_mag == '0, longint'(tx_mag), 0);
  endtask

  localparam int NV = 11;
  longint vx[NV] = '{1000, 0, -1000, 1000, 1000, 0, -64'sd2147483648,
                     -3000, 20000, 64'sd1073741824, -500000};
  longint vy[NV] = '{1000, 1000, 0, -1000, 0, 0, -64'sd2147483648,
                     4000, -7000, 123456789, -1};
  int     vz[NV] = '{512, 1024, 2048, 3584, 0, 0, 2560, -1, -1, -1, -1};
  longint vm[NV] = '{-1, -1, -1, -1, MAG1000, 0, -1, -1, -1, -1, -1};
  int     vt[NV] = '{3, 3, 3, 3, 3, 0, 3, 0, 0, 0, 0};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int acc_a;
    int acc_b;
    int h;
    bit seen;

    rx_rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 rx_rst = 1'b1;
    @(posedge clk); #1;
    expect_reset_state("reset");

    for (int k = 0; k < NV; k++) begin
      send(vx[k], vy[k], vz[k], vm[k], vt[k], acc_a);
      wait_idle();
    end

    // Back-to-back: second vector accepted one IDLE cycle after the handshake.
    send(1000, 1000, 512, -1, 3, acc_a);
    send(-3000, 4000, -1, -1, 0, acc_b);
    check("throughput", (acc_b - acc_a) == LAT + 1, acc_b - acc_a, LAT + 1);
    wait_idle();

    // Backpressure with a second request pending.
    tx_ready = 1'b0;
    send(20000, -7000, -1, -1, 0, acc_a);
    h = 0;
    while (!tx_valid && h < 100) begin
      @(posedge clk); #1;
      h++;
    end
    check("bp_valid_seen", tx_valid == 1'b1, tx_valid, 1);
    rx_x     = 32'sd0;
    rx_y     = 32'sd1000;
    rx_valid = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      check("bp_rx_ready_low", rx_ready == 1'b0, rx_ready, 0);
      check("bp_valid_held", tx_valid == 1'b1, tx_valid, 1);
    end
    tx_ready = 1'b1;
    h = cyc;
    send(0, 1000, 1024, -1, 3, acc_b);
    check("bp_accept_after_hs", acc_b == h + 1, acc_b - h, 1);
    wait_idle();

    // Flush at RUN iteration 4.
    send(1000, 1000, 512, -1, 3, acc_a);
    repeat (4) begin @(posedge clk); #1; end
    rx_flush = 1'b1;
    @(posedge clk); #1;
    rx_flush = 1'b0;
    q.delete();
    check("flush_busy", busy == 1'b0, busy, 0);
    check("flush_rx_ready", rx_ready == 1'b1, rx_ready, 1);
    seen = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      if (tx_valid) seen = 1'b1;
    end
    check("flush_no_valid", !seen, seen, 0);

    // Flush together with rx_valid in IDLE: nothing captured.
    rx_x     = 32'sd777;
    rx_y     = 32'sd555;
    rx_valid = 1'b1;
    rx_flush = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    rx_flush = 1'b0;
    check("idle_flush_busy", busy == 1'b0, busy, 0);
    seen = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      if (tx_valid || busy) seen = 1'b1;
    end
    check("idle_flush_no_op", !seen, seen, 0);

    // Reset in the middle of RUN.
    send(-3000, 4000, -1, -1, 0, acc_a);
    repeat (3) begin @(posedge clk); #1; end
    rx_rst = 1'b0;
    @(posedge clk); #1;
    q.delete();
    expect_reset_state("midrun_reset");
    rx_rst = 1'b1;
    @(posedge clk); #1;

    send(1000, -1000, 3584, -1, 3, acc_a);
    wait_idle();

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
